// File: rtl/parity_word_encoder_pkg.sv
// ---------------------------------------------------------------------------
// parity_word_encoder_pkg
//
// Purpose : Shared constants, types and helpers for the parity word encoder
//           and its storage FIFO.
//           A coded word has 16 bits. Bits [15:1] hold the 15-bit data and
//           bit [0] holds an odd-parity bit, so every coded word contains an
//           odd number of ones.
//
// Contents: DATA_W, WORD_W, PARITY_BIT, NEG_ZERO constants
//           coded_word_t  - packed {data, parity} view of a coded word
//           fifo_op_e     - per-edge FIFO operation (idle/pop/push/both)
//           odd_parity()  - parity bit that makes {data, parity} odd-weight
//           encode_word() - builds a coded_word_t from 15-bit data
// ---------------------------------------------------------------------------
package parity_word_encoder_pkg;

    localparam int DATA_W     = 15;
    localparam int WORD_W     = 16;
    localparam int PARITY_BIT = 0;

    // One's-complement negative zero (all data bits set).
    localparam logic [DATA_W-1:0] NEG_ZERO = 15'h7FFF;

    // Field order puts parity at bit 0 and data at [15:1].
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              parity;
    } coded_word_t;

    // Encoded as {push, pop} so the FIFO can cast its two strobes directly.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // The reduction XNOR is 1 when the data already has an even number of
    // ones, which is exactly when one more '1' is needed to make it odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] data);
        return ~^data;
    endfunction

    function automatic coded_word_t encode_word(input logic [DATA_W-1:0] data);
        coded_word_t word;
        word.data   = data;
        word.parity = odd_parity(data);
        return word;
    endfunction

endpackage

// File: rtl/parity_word_encoder_fifo.sv
// ---------------------------------------------------------------------------
// parity_word_fifo
//
// Purpose : Generic synchronous FIFO with wrapping read/write pointers and an
//           occupancy counter. It knows nothing about parity or data format.
//
// Parameters:
//   WIDTH  - entry width in bits
//   DEPTH  - number of entries (power of two, 2..16)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (pointers, count, hold reg)
//   push     in   write wr_data this edge (ignored while full)
//   wr_data  in   WIDTH-bit word to write
//   pop      in   retire the head entry this edge (ignored while empty)
//   rd_data  out  head entry; while empty, the last word popped (0 after reset)
//   count    out  number of entries held, $clog2(DEPTH)+1 bits
//   full     out  count == DEPTH
//   empty    out  count == 0
// ---------------------------------------------------------------------------
module parity_word_fifo
    import parity_word_encoder_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] last_word;
    logic             do_push;
    logic             do_pop;
    fifo_op_e         op;

    // Pointers wrap explicitly at DEPTH-1 rather than relying on natural
    // overflow, so the intent stays obvious if DEPTH rules ever change.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Qualify the requests against full/empty so a stray push or pop from the
    // caller can never corrupt the pointers or the count.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        op      = fifo_op_e'({do_push, do_pop});
    end

    // Pointer and occupancy update; a simultaneous push and pop moves both
    // pointers and leaves the count where it was.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    count_q <= count_q + CNT_W'(1);
                end
                FIFO_POP: begin
                    rd_ptr  <= ptr_inc(rd_ptr);
                    count_q <= count_q - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                default: begin
                end
            endcase
        end
    end

    // Storage is deliberately not reset; stale entries are never visible
    // because rd_data switches to the hold register whenever empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Holds the most recently retired word so the read port keeps a steady
    // value once the FIFO drains, and reads zero after a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_word <= '0;
        end else if (do_pop) begin
            last_word <= mem[rd_ptr];
        end
    end

    // Head of queue, straight from registers; no write-to-read bypass.
    always_comb begin
        rd_data = empty ? last_word : mem[rd_ptr];
    end

endmodule

// File: rtl/parity_word_encoder.sv
// ---------------------------------------------------------------------------
// parity_word_encoder
//
// Purpose : Accepts 15-bit one's-complement ALU results, appends an odd
//           parity bit at bit 0, and buffers the resulting 16-bit words in a
//           DEPTH-entry FIFO with valid/ready handshakes on both sides.
//           Also keeps an 8-bit wrapping count of completed output transfers.
//
// Build option:
//   NEG_ZERO_NORM_EN - when defined, an input of 15'h7FFF (-0) is encoded as
//                      +0 (word 16'h0001); otherwise -0 is encoded unchanged
//                      (word 16'hFFFE).
//
// Parameters:
//   DEPTH      - buffered words, power of two 2..16 (default 4)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_data    in   15-bit one's-complement value
//   in_valid   in   in_data presented
//   in_ready   out  encoder can accept in_data this cycle (buffer not full)
//   out_word   out  [15:1] data, [0] odd parity, head of buffer
//   out_valid  out  out_word holds a buffered word
//   out_ready  in   consumer takes out_word this cycle
//   count      out  words currently buffered
//   words_sent out  completed output transfers, modulo 256
// ---------------------------------------------------------------------------
module parity_word_encoder
    import parity_word_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_W-1:0]        out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               words_sent
);

    logic [DATA_W-1:0] norm_data;
    coded_word_t       enc_word;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef NEG_ZERO_NORM_EN
    // Collapse the two one's-complement zeros onto +0 before encoding.
    always_comb begin
        norm_data = (in_data == NEG_ZERO) ? '0 : in_data;
    end
`else
    // Both zero representations pass through untouched.
    always_comb begin
        norm_data = in_data;
    end
`endif

    // Encoding is done at push time so each FIFO entry already carries its
    // final parity and the read side is a plain register read.
    always_comb begin
        enc_word = encode_word(norm_data);
    end

    // Ready/valid are derived only from registered occupancy; in_ready does
    // not look at out_ready, so a full buffer takes one edge to reopen.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    parity_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (enc_word),
        .pop     (pop),
        .rd_data (out_word),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Counts completed output handshakes; natural 8-bit overflow gives the
    // wrap from 255 back to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_sent <= '0;
        end else if (pop) begin
            words_sent <= words_sent + 8'd1;
        end
    end

endmodule
